pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register for the 8-bit pipelined core (IF/ID .. MEM/WB).
//  Carries separate control and data fields under a valid/ready handshake with stall and flush.
//  Inserts bubbles: an empty stage presents the safe control word CTRL_RST_VAL.
//  Optional skid buffer registers the ready path; a saturating counter reports stall cycles.
// PARAMETERS
//  CTRL_W        12      width of control field (write enables, mux selects, PC_Sel, flags)
//  DATA_W        40      width of data field (e.g. 5 x 8-bit operands/results)
//  CTRL_RST_VAL  12'h001 control word on reset and on bubbles (e.g. PC_Sel=2'b01, all enables 0)
//  CNT_W         16      width of stall counter
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       synchronous kill of all held and incoming entries
//  in_valid   in   1       upstream stage presents a valid entry
//  in_ready   out  1       this stage accepts an entry this cycle
//  in_ctrl    in   CTRL_W  upstream control field
//  in_data    in   DATA_W  upstream data field
//  out_valid  out  1       entry valid toward downstream stage
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_ctrl   out  CTRL_W  control field; CTRL_RST_VAL whenever out_valid=0
//  out_data   out  DATA_W  data field; holds last value when out_valid=0
//  stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0, saturating
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset (reset=1 at edge): out_valid=0, out_ctrl=CTRL_RST_VAL, out_data=0, skid empty,
//    stall_cnt=0, in_ready=1 from the following cycle. Reset beats flush beats all else.
//  - Accept = in_valid & in_ready; emit = out_valid & out_ready. Order strictly preserved.
//  - Latency 1 cycle in->out; throughput 1 entry/cycle when out_ready held 1.
//  - out_ctrl is a register, not gated: it is loaded with CTRL_RST_VAL whenever the stage
//    goes empty, so downstream never sees stale write enables on a bubble.
//  - Flush=1 at edge: all held entries dropped, any beat accepted that cycle discarded,
//    out_valid=0, out_ctrl=CTRL_RST_VAL next cycle; out_data unchanged; stall_cnt unchanged.
//    in_ready is not gated by flush.
//  - Stall: out_valid=1, out_ready=0 -> out_ctrl/out_data held bit-exact; stall_cnt+1 per
//    such cycle, sticks at 2^CNT_W-1; cleared only by reset.
//  - Simultaneous accept and emit in same cycle: new entry replaces emitted one, no bubble.
//  - Only out_valid, out_ctrl, out_data, stall_cnt (and skid state) hold state; no other regs.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined: two-entry skid (main + skid register).
//   - in_ready is a flop output = ~skid_valid; no combinational out_ready->in_ready path.
//   - Main full, out_ready=0, accept -> entry parks in skid; in_ready=0 next cycle.
//   - out_ready=1 with skid full: main<=skid, skid empties, in_ready=1 next cycle;
//     a beat accepted in that same cycle is impossible (in_ready was 0).
//   - Flush clears both entries. Max 2 entries held; latency still 1 when unstalled.
//  Not defined: single register; in_ready = ~out_valid | out_ready (combinational).
// TESTING
//  1 Reset: reset=1 two cycles with in_valid=1 -> out_valid=0, out_ctrl=12'h001,
//    out_data=0, stall_cnt=0; first beat after release appears 1 cycle later.
//  2 Stream: 8 beats data=i*0x11, out_ready=1 -> out_data 0x00,0x11..0x77 on 8
//    consecutive cycles, ctrl matches, no gaps, stall_cnt=0.
//  3 Stall: hold out_ready=0 for 5 cycles on data=0xA5 -> out_data stays 0xA5, stall_cnt=5;
//    skid build: second beat 0x5A parks, in_ready=0; release -> 0xA5 then 0x5A in order;
//    no-skid build: in_ready=0 throughout stall.
//  4 Flush: flush=1 while full (both entries in skid build) and in_valid=1 data=0x3C ->
//    next cycle out_valid=0, out_ctrl=12'h001, 0x3C never emitted.
//  5 Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15; then reset -> stall_cnt=0.
//  6 Random: random in_valid/out_ready/flush 10k cycles vs scoreboard -> no loss/dup/reorder.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, bubble control word and
// saturating stall counter. Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg #(
  parameter int unsigned          CTRL_W       = 12,
  parameter int unsigned          DATA_W       = 40,
  parameter logic [CTRL_W-1:0]    CTRL_RST_VAL = CTRL_W'(12'h001),
  parameter int unsigned          CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q;

  logic accept;
  logic emit;
  logic stall;

  assign emit  = valid_q & out_ready;
  assign stall = valid_q & ~out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // in_ready depends only on state, cutting the out_ready -> in_ready path.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      valid_d      = 1'b0;
      ctrl_d       = CTRL_RST_VAL;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full implies main full and no accept possible this cycle.
      if (out_ready) begin
        valid_d      = 1'b1;
        ctrl_d       = skid_ctrl_q;
        data_d       = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (!valid_q || out_ready) begin
      if (accept) begin
        valid_d = 1'b1;
        ctrl_d  = in_ctrl;
        data_d  = in_data;
      end else if (valid_q) begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_RST_VAL;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= CTRL_RST_VAL;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

`else

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_RST_VAL;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end else if (emit) begin
      // Going empty: load the safe control word so a bubble never carries stale enables.
      valid_d = 1'b0;
      ctrl_d  = CTRL_RST_VAL;
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_RST_VAL;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  // A flush cycle leaves the counter untouched even if the stage was stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stall && !flush && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard bench for pipe_stage_reg; follows PIPE_STAGE_SKID_EN if defined.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_ctrl;
  logic [39:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_ctrl;
  logic [39:0] out_data;
  logic [15:0] stall_cnt;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [11:0] sat_out_ctrl;
  logic [39:0] sat_out_data;
  logic [3:0]  sat_stall_cnt;

  int checks;
  int passes;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  pipe_stage_reg #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  // Same stimulus, narrow counter for saturation.
  pipe_stage_reg #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (sat_in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (sat_out_valid),
    .out_ready (out_ready),
    .out_ctrl  (sat_out_ctrl),
    .out_data  (sat_out_data),
    .stall_cnt (sat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 12'hABC; in_data = 40'hFF;
    out_ready = 1'b1;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else passes++;
    checks++; if (out_ctrl !== 12'h001) $display("FAIL reset_ctrl: got %h want 001", out_ctrl);
    else passes++;
    checks++; if (out_data !== 40'h0) $display("FAIL reset_data: got %h want 0", out_data);
    else passes++;
    checks++; if (stall_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
    else passes++;
    reset = 1'b0; in_ctrl = 12'h155; in_data = 40'h42;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 40'h42 || out_ctrl !== 12'h155)
      $display("FAIL first_beat: got v=%b c=%h d=%h want v=1 c=155 d=42",
               out_valid, out_ctrl, out_data);
    else passes++;
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 12'h001 || out_data !== 40'h42)
      $display("FAIL bubble: got v=%b c=%h d=%h want v=0 c=001 d=42",
               out_valid, out_ctrl, out_data);
    else passes++;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 40'(i * 8'h11);
      in_ctrl  = 12'h100 | 12'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 40'(i * 8'h11) || out_ctrl !== (12'h100 | 12'(i)))
        $display("FAIL stream_%0d: got v=%b c=%h d=%h want v=1 c=%h d=%h", i, out_valid,
                 out_ctrl, out_data, 12'h100 | 12'(i), 40'(i * 8'h11));
      else passes++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL stream_end: got %b want 0", out_valid);
    else passes++;
    checks++; if (stall_cnt !== 16'd0) $display("FAIL stream_cnt: got %0d want 0", stall_cnt);
    else passes++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 40'hA5; in_ctrl = 12'h0A5;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 40'hA5)
      $display("FAIL stall_load: got v=%b d=%h want v=1 d=a5", out_valid, out_data);
    else passes++;
    in_data = 40'h5A; in_ctrl = 12'h05A;
    #1;
    checks++;
    if (in_ready !== Skid) $display("FAIL stall_ready0: got %b want %b", in_ready, Skid);
    else passes++;
    tick();
    if (Skid) in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready1: got %b want 0", in_ready);
    else passes++;
    repeat (4) begin
      tick();
      checks++;
      if (out_data !== 40'hA5 || out_ctrl !== 12'h0A5 || out_valid !== 1'b1)
        $display("FAIL stall_hold: got v=%b c=%h d=%h want v=1 c=0a5 d=a5",
                 out_valid, out_ctrl, out_data);
      else passes++;
    end
    checks++; if (stall_cnt !== 16'd5) $display("FAIL stall_cnt: got %0d want 5", stall_cnt);
    else passes++;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== !Skid) $display("FAIL release_ready: got %b want %b", in_ready, !Skid);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 40'h5A || out_ctrl !== 12'h05A)
      $display("FAIL release_second: got v=%b c=%h d=%h want v=1 c=05a d=5a",
               out_valid, out_ctrl, out_data);
    else passes++;
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 12'h001 || stall_cnt !== 16'd5)
      $display("FAIL release_drain: got v=%b c=%h cnt=%0d want v=0 c=001 cnt=5",
               out_valid, out_ctrl, stall_cnt);
    else passes++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 40'h11; in_ctrl = 12'h211;
    tick();
    if (Skid) begin
      in_data = 40'h22; in_ctrl = 12'h222;
      tick();
    end
    // out_ready=1 so the no-skid build genuinely accepts the beat that flush must discard.
    flush = 1'b1; in_data = 40'h3C; in_ctrl = 12'h33C; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 12'h001 || out_data !== 40'h11)
      $display("FAIL flush_state: got v=%b c=%h d=%h want v=0 c=001 d=11",
               out_valid, out_ctrl, out_data);
    else passes++;
    checks++;
    if (stall_cnt !== (Skid ? 16'd6 : 16'd5))
      $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, Skid ? 6 : 5);
    else passes++;
    repeat (3) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== 12'h001)
        $display("FAIL flush_leak: got v=%b c=%h d=%h want v=0 c=001",
                 out_valid, out_ctrl, out_data);
      else passes++;
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 40'h77; in_ctrl = 12'h077;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    checks++; if (stall_cnt !== 16'd20) $display("FAIL cnt_wide: got %0d want 20", stall_cnt);
    else passes++;
    checks++;
    if (sat_stall_cnt !== 4'd15) $display("FAIL cnt_sat: got %0d want 15", sat_stall_cnt);
    else passes++;
    reset = 1'b1;
    tick();
    checks++;
    if (stall_cnt !== 16'd0 || sat_stall_cnt !== 4'd0 || out_valid !== 1'b0)
      $display("FAIL cnt_clear: got cnt=%0d sat=%0d v=%b want 0 0 0",
               stall_cnt, sat_stall_cnt, out_valid);
    else passes++;
    reset = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [11:0] qc[$];
    logic [39:0] qd[$];
    logic acc;
    logic em;
    int   errs;
    errs = 0;
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = {8'($urandom), $urandom};
      in_ctrl   = 12'($urandom);
      #1;
      acc = in_valid & in_ready;
      em  = out_valid & out_ready;
      if (em) begin
        checks++;
        if (qd.size() == 0) begin
          if (errs++ < 10) $display("FAIL rand_extra @%0d: got d=%h want none", n, out_data);
        end else if (out_data !== qd[0] || out_ctrl !== qc[0]) begin
          if (errs++ < 10)
            $display("FAIL rand_order @%0d: got c=%h d=%h want c=%h d=%h",
                     n, out_ctrl, out_data, qc[0], qd[0]);
        end else passes++;
        if (qd.size() != 0) begin
          void'(qd.pop_front());
          void'(qc.pop_front());
        end
      end
      if (acc) begin
        qd.push_back(in_data);
        qc.push_back(in_ctrl);
      end
      if (flush) begin
        qd.delete();
        qc.delete();
      end
      tick();
      checks++;
      if (out_valid !== (qd.size() != 0) || (!out_valid && out_ctrl !== 12'h001)) begin
        if (errs++ < 10)
          $display("FAIL rand_valid @%0d: got v=%b c=%h want v=%b held=%0d",
                   n, out_valid, out_ctrl, qd.size() != 0, qd.size());
      end else passes++;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
